issue_sched: RTL and testbench

ISSUE_SCHED -- requirements
Module: issue_sched

---
 rtl/issue_sched_pkg.sv | 35 +++
 rtl/issue_sched_if.sv | 29 ++
 rtl/inst_class_dec.sv | 77 +++++++
 rtl/issue_sched.sv | 95 +++++++++
 tb/tb_issue_sched.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/issue_sched_pkg.sv
// Shared decode constants, FSM state and instruction-class types for the
// dual-issue scheduler.
package issue_sched_pkg;

  localparam logic [5:0] OP_XFORM = 6'd31;
  localparam logic [5:0] OP_ADDI  = 6'd14;
  localparam logic [5:0] OP_LD    = 6'd58;
  localparam logic [5:0] OP_STD   = 6'd62;
  localparam logic [5:0] OP_SC    = 6'd17;

  localparam logic [9:0] XO_ADD   = 10'd266;
  localparam logic [9:0] XO_OR    = 10'd444;
  localparam logic [9:0] XO_MTSPR = 10'd467;
  localparam logic [9:0] XO_MFSPR = 10'd339;
  localparam logic [9:0] XO_MTCRF = 10'd144;

  typedef enum logic {RUN, HALTED} SchedState;

  typedef enum logic [2:0] {CLS_ALU, CLS_MEM, CLS_SPR, CLS_SC, CLS_BAD} InstClass;

  typedef struct packed {
    logic       valid;
    logic [4:0] gpr;
  } RegRef;

  function automatic logic refHit(RegRef a, RegRef b);
    return a.valid && b.valid && (a.gpr == b.gpr);
  endfunction

  // Only plain ALU and memory ops may share an issue cycle.
  function automatic logic pairable(InstClass c);
    return (c == CLS_ALU) || (c == CLS_MEM);
  endfunction

endpackage

// File: rtl/issue_sched_if.sv
// Fetch-side and issue-side signals of the scheduler; slave is the scheduler,
// master is whoever feeds fetch words and accepts issued instructions.
interface issue_sched_if #(parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fetch_valid;
  logic [63:0]   fetch_data;
  logic          fetch_ready;
  logic          flush;
  logic          issue_ready;
  logic          issue0_valid;
  logic [31:0]   issue0_inst;
  logic          issue1_valid;
  logic [31:0]   issue1_inst;
  logic          halted;
  logic [CW-1:0] count;

  modport master (
    output fetch_valid, fetch_data, flush, issue_ready,
    input  fetch_ready, issue0_valid, issue0_inst, issue1_valid, issue1_inst,
           halted, count
  );

  modport slave (
    input  fetch_valid, fetch_data, flush, issue_ready,
    output fetch_ready, issue0_valid, issue0_inst, issue1_valid, issue1_inst,
           halted, count
  );
endinterface

// File: rtl/inst_class_dec.sv
// Single-slot decoder: classifies one instruction and lists the GPRs it
// writes and reads. Field positions follow IBM numbering (bit 0 = MSB).
module inst_class_dec
  import issue_sched_pkg::*;
(
  input  logic [31:0] inst,
  output InstClass    cls,
  output RegRef [1:0] dst,
  output RegRef [1:0] src
);

  logic [5:0] op;
  logic [4:0] rt, ra, rb;
  logic [9:0] xo;
  logic [1:0] dsXo;

  assign op   = inst[31:26];
  assign rt   = inst[25:21];
  assign ra   = inst[20:16];
  assign rb   = inst[15:11];
  assign xo   = inst[10:1];
  assign dsXo = inst[1:0];

  always_comb begin
    cls = CLS_BAD;
    dst = '0;
    src = '0;
    case (op)
      OP_ADDI: begin
        cls    = CLS_ALU;
        dst[0] = '{1'b1, rt};
        src[0] = '{ra != 5'd0, ra};
      end
      OP_LD: begin
        if (dsXo == 2'd0) begin
          cls    = CLS_MEM;
          dst[0] = '{1'b1, rt};
          src[0] = '{ra != 5'd0, ra};
        end else if (dsXo == 2'd1) begin
          // ldu writes the updated base back into ra.
          cls    = CLS_MEM;
          dst[0] = '{1'b1, rt};
          dst[1] = '{1'b1, ra};
          src[0] = '{1'b1, ra};
        end
      end
      OP_STD: begin
        if (dsXo == 2'd0) begin
          cls    = CLS_MEM;
          src[0] = '{1'b1, rt};
          src[1] = '{ra != 5'd0, ra};
        end
      end
      OP_SC: cls = CLS_SC;
      OP_XFORM: begin
        case (xo)
          XO_ADD: begin
            cls    = CLS_ALU;
            dst[0] = '{1'b1, rt};
            src[0] = '{1'b1, ra};
            src[1] = '{1'b1, rb};
          end
          XO_OR: begin
            cls    = CLS_ALU;
            dst[0] = '{1'b1, ra};
            src[0] = '{1'b1, rt};
            src[1] = '{1'b1, rb};
          end
          XO_MTSPR, XO_MFSPR, XO_MTCRF: cls = CLS_SPR;
          default: cls = CLS_BAD;
        endcase
      end
      default: cls = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/issue_sched.sv
// Circular instruction queue filled two words per fetch, offering its two
// oldest entries to the D0/D1 issue slots; an issued sc halts until flush.
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic          clk,
  input logic          reset,
  issue_sched_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] head, tail, headNext1, tailNext1;
  logic [CW-1:0] count;
  SchedState     state, stateNext;

  logic [31:0]   inst0, inst1;
  InstClass      cls0, cls1;
  RegRef [1:0]   dst0, dst1, src1, unusedSrc0;
  logic          hazard, pairOk, running, valid0, valid1, fetchReady, push, pop;

  assign headNext1 = head + AW'(1);
  assign tailNext1 = tail + AW'(1);
  assign inst0     = mem[head];
  assign inst1     = mem[headNext1];

  inst_class_dec uDec0 (.inst(inst0), .cls(cls0), .dst(dst0), .src(unusedSrc0));
  inst_class_dec uDec1 (.inst(inst1), .cls(cls1), .dst(dst1), .src(src1));

  // RAW: I1 reads what I0 writes; WAW: both write the same GPR.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        hazard = hazard | refHit(src1[i], dst0[j]) | refHit(dst1[i], dst0[j]);
  end

  assign pairOk     = pairable(cls0) && pairable(cls1) &&
                      !(cls0 == CLS_MEM && cls1 == CLS_MEM) && !hazard;
  assign running    = (state == RUN);
  assign valid0     = running && (count != '0);
  assign valid1     = valid0 && (count >= CW'(2)) && pairOk;
  assign fetchReady = running && ((CW'(DEPTH) - count) >= CW'(2));
  assign push       = bus.fetch_valid && fetchReady;
  assign pop        = bus.issue_ready && valid0;

  // NOTE: default assigned first so every path drives stateNext (no latch).
  always_comb begin
    stateNext = state;
    case (state)
      RUN:    if (pop && cls0 == CLS_SC) stateNext = HALTED;
      HALTED: stateNext = HALTED;
    endcase
    if (bus.flush) stateNext = RUN;
  end

  // NOTE: non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + (valid1 ? AW'(2) : AW'(1));
      if (push) tail <= tail + AW'(2);
      count <= count + (push ? CW'(2) : CW'(0)) - (pop ? (valid1 ? CW'(2) : CW'(1)) : CW'(0));
    end
  end

  // NOTE: storage has no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset && !bus.flush) begin
      mem[tail]      <= bus.fetch_data[63:32];
      mem[tailNext1] <= bus.fetch_data[31:0];
    end
  end

  assign bus.fetch_ready  = fetchReady;
  assign bus.issue0_valid = valid0;
  assign bus.issue0_inst  = inst0;
  assign bus.issue1_valid = valid1;
  assign bus.issue1_inst  = inst1;
  assign bus.halted       = (state == HALTED);
  assign bus.count        = count;

endmodule

// File: tb/tb_issue_sched.sv
// Self-checking bench for issue_sched: directed pairing/halt/fill cases, then
// random traffic compared against a queue-based reference model.
module tb_issue_sched;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;

  logic [31:0] q[$];
  bit          mHalted;

  issue_sched_if #(.DEPTH(DEPTH)) bus ();
  issue_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic string mnem(input logic [31:0] w);
    int unsigned op = w[31:26];
    int unsigned xo = w[10:1];
    int unsigned ds = w[1:0];
    case (op)
      14: return "addi";
      17: return "sc";
      58: return (ds == 0) ? "ld" : (ds == 1) ? "ldu" : "bad";
      62: return (ds == 0) ? "std" : "bad";
      31: case (xo)
            266: return "add";
            444: return "or";
            467: return "mtspr";
            339: return "mfspr";
            144: return "mtcrf";
            default: return "bad";
          endcase
      default: return "bad";
    endcase
  endfunction

  // Destination and source GPR sets as one-hot masks over r0..r31.
  function automatic void regSets(input logic [31:0] w, output bit [31:0] d, output bit [31:0] s);
    string m = mnem(w);
    int rt = int'(w[25:21]);
    int ra = int'(w[20:16]);
    int rb = int'(w[15:11]);
    bit [31:0] raOpt = (ra == 0) ? 32'd0 : (32'd1 << ra);
    d = 0;
    s = 0;
    if (m == "add")  begin d = 32'd1 << rt; s = (32'd1 << ra) | (32'd1 << rb); end
    if (m == "or")   begin d = 32'd1 << ra; s = (32'd1 << rt) | (32'd1 << rb); end
    if (m == "addi" || m == "ld") begin d = 32'd1 << rt; s = raOpt; end
    if (m == "ldu")  begin d = (32'd1 << rt) | (32'd1 << ra); s = 32'd1 << ra; end
    if (m == "std")  begin d = 0; s = (32'd1 << rt) | raOpt; end
  endfunction

  function automatic bit isMem(input string m);
    return m == "ld" || m == "ldu" || m == "std";
  endfunction

  function automatic bit pairOk(input logic [31:0] a, input logic [31:0] b);
    string ma = mnem(a);
    string mb = mnem(b);
    bit [31:0] da, sa, db, sb;
    if (!(isMem(ma) || ma == "add" || ma == "or" || ma == "addi")) return 0;
    if (!(isMem(mb) || mb == "add" || mb == "or" || mb == "addi")) return 0;
    if (isMem(ma) && isMem(mb)) return 0;
    regSets(a, da, sa);
    regSets(b, db, sb);
    return ((sb & da) == 0) && ((db & da) == 0);
  endfunction

  // One clock: drive inputs, compare outputs against the model, advance both.
  task automatic cycle(input bit fv, input logic [63:0] fd, input bit fl, input bit ir, input bit rs);
    int n;
    bit e0, e1, efr;
    bus.fetch_valid = fv;
    bus.fetch_data  = fd;
    bus.flush       = fl;
    bus.issue_ready = ir;
    reset           = rs;
    #1;
    n   = q.size();
    e0  = !mHalted && n >= 1;
    e1  = e0 && n >= 2 && pairOk(q[0], q[1]);
    efr = !mHalted && (DEPTH - n) >= 2;
    check("issue0_valid", bus.issue0_valid, e0);
    check("issue1_valid", bus.issue1_valid, e1);
    check("fetch_ready", bus.fetch_ready, efr);
    check("halted", bus.halted, mHalted);
    check("count", bus.count, n);
    if (e0) check("issue0_inst", bus.issue0_inst, q[0]);
    if (!mHalted && n >= 2) check("issue1_inst", bus.issue1_inst, q[1]);
    if (rs || fl) begin
      q.delete();
      mHalted = 0;
    end else begin
      if (ir && e0) begin
        if (mnem(q[0]) == "sc") mHalted = 1;
        void'(q.pop_front());
        if (e1) void'(q.pop_front());
      end
      if (fv && efr) begin
        q.push_back(fd[63:32]);
        q.push_back(fd[31:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ir);
    for (int i = 0; i < n; i++) cycle(0, 64'd0, 0, ir, 0);
  endtask

  function automatic logic [31:0] randInst();
    logic [4:0]  a   = 5'($urandom_range(0, 7));
    logic [4:0]  b   = 5'($urandom_range(0, 7));
    logic [4:0]  c   = 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    int k = $urandom_range(0, 39);
    if (k < 8)  return {6'd14, a, b, imm};
    if (k < 14) return {6'd31, a, b, c, 10'd266, 1'b0};
    if (k < 18) return {6'd31, a, b, c, 10'd444, 1'b0};
    if (k < 23) return {6'd58, a, b, imm[13:0], 2'd0};
    if (k < 26) return {6'd58, a, b, imm[13:0], 2'd1};
    if (k < 31) return {6'd62, a, b, imm[13:0], 2'd0};
    if (k < 33) return {6'd31, a, imm[9:0], 10'd467, 1'b0};
    if (k < 34) return {6'd31, a, imm[9:0], 10'd339, 1'b0};
    if (k < 35) return {6'd31, a, 1'b0, imm[7:0], 1'b0, 10'd144, 1'b0};
    if (k < 36) return 32'h4400_0002;
    if (k < 38) return {6'd58, a, b, imm[13:0], 2'd2};
    return {6'd31, a, b, c, 10'd235, 1'b0};
  endfunction

  initial begin
    bus.fetch_valid = 0;
    bus.fetch_data  = '0;
    bus.flush       = 0;
    bus.issue_ready = 0;
    reset           = 1;
    mHalted         = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_count", bus.count, 0);
    check("rst_fetch_ready", bus.fetch_ready, 1);
    check("rst_issue0_valid", bus.issue0_valid, 0);
    check("rst_issue1_valid", bus.issue1_valid, 0);
    check("rst_halted", bus.halted, 0);

    // addi r3 then add r4,r3,r3: RAW forces two single issues.
    cycle(1, {32'h3860_0005, 32'h7C83_1A14}, 0, 1, 0);
    check("raw_v1", bus.issue1_valid, 0);
    check("raw_i0", bus.issue0_inst, 32'h3860_0005);
    idle(1, 1);
    check("raw_add_alone", bus.issue0_inst, 32'h7C83_1A14);
    check("raw_count", bus.count, 1);
    idle(1, 1);

    // Two independent addi issue together.
    cycle(1, {32'h3860_0005, 32'h38A0_0001}, 0, 1, 0);
    check("dual_v1", bus.issue1_valid, 1);
    idle(1, 1);
    check("dual_count", bus.count, 0);

    // ld + std share the single data port.
    cycle(1, {32'hE8C1_0000, 32'hF8E1_0008}, 0, 1, 0);
    check("mem_v1", bus.issue1_valid, 0);
    idle(2, 1);

    // sc issues alone and halts with the addi held.
    cycle(1, {32'h4400_0002, 32'h3860_0005}, 0, 1, 0);
    check("sc_v1", bus.issue1_valid, 0);
    idle(1, 1);
    check("sc_halted", bus.halted, 1);
    check("sc_count", bus.count, 1);
    idle(3, 1);
    check("sc_held", bus.count, 1);

    // Flush leaves the halt and empties the queue.
    cycle(0, 64'd0, 1, 1, 0);
    check("flush_halted", bus.halted, 0);
    check("flush_count", bus.count, 0);

    // Fill to DEPTH with nothing draining, then pop and push around the wrap.
    for (int i = 0; i < DEPTH / 2; i++)
      cycle(1, {6'd14, 5'(2 * i), 21'd0, 6'd14, 5'(2 * i + 1), 21'd7}, 0, 0, 0);
    check("full_count", bus.count, DEPTH);
    check("full_fetch_ready", bus.fetch_ready, 0);
    cycle(1, {32'h3860_0009, 32'h38A0_0009}, 0, 1, 0);
    cycle(1, {32'h3860_000A, 32'h38A0_000A}, 0, 1, 0);
    cycle(1, {32'h3860_000B, 32'h38A0_000B}, 0, 0, 0);
    check("refill_count", bus.count, DEPTH);
    idle(DEPTH, 1);

    // Reset mid-operation discards everything and beats a same-cycle flush.
    cycle(1, {32'h3860_0005, 32'h38A0_0001}, 0, 0, 0);
    cycle(1, {32'h3860_0005, 32'h38A0_0001}, 1, 1, 1);
    check("midrst_count", bus.count, 0);
    check("midrst_fetch_ready", bus.fetch_ready, 1);

    for (int i = 0; i < 3000; i++) begin
      bit rs = ($urandom_range(0, 199) == 0);
      bit fl = mHalted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      bit fv = ($urandom_range(0, 9) < 7);
      bit ir = ($urandom_range(0, 9) < 6);
      cycle(fv, {randInst(), randInst()}, fl, ir, rs);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
